// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : input_debouncer
//  Purpose  : Synchronises, debounces and rise-edge-detects the vehicle
//             sensor, walk button and reprogram button for the traffic
//             controller core. Three identical, independent channels.
//  Revision : 1.0 - initial release
// ============================================================================
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic Reset,
    input  logic Sensor,
    input  logic Walk_Request,
    input  logic Reprogram,
    output logic Sensor_Clean,
    output logic WR_Level,
    output logic Reprog_Level,
    output logic WR_Pulse,
    output logic Reprog_Pulse,
    output logic Sensor_Rise
);

    // Terminal count: the edge on which a persistent disagreement is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Channel order: 0 = sensor, 1 = walk button, 2 = reprogram button.
    logic [2:0] raw_in;
    logic [2:0] level;
    logic [2:0] pulse;

    assign raw_in = {Reprogram, Walk_Request, Sensor};

    genvar ch;
    generate
        for (ch = 0; ch < 3; ch++) begin : g_ch
            logic             sync1;
            logic             sync2;
            logic             stable;
            logic             rise;
            logic [CNT_W-1:0] cnt;

            // Two-flop synchroniser for the asynchronous pin.
            always_ff @(posedge clk or posedge Reset) begin
                if (Reset) begin
                    sync1 <= 1'b0;
                    sync2 <= 1'b0;
                end else begin
                    sync1 <= raw_in[ch];
                    sync2 <= sync1;
                end
            end

            // Debounce: accept a new level only after it has persisted for
            // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
            always_ff @(posedge clk or posedge Reset) begin
                if (Reset) begin
                    cnt    <= '0;
                    stable <= 1'b0;
                    rise   <= 1'b0;
                end else if (sync2 == stable) begin
                    cnt  <= '0;
                    rise <= 1'b0;
                end else if (cnt == CNT_LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                    rise   <= sync2;   // pulse only when the new level is high
                end else begin
                    cnt  <= cnt + CNT_ONE;
                    rise <= 1'b0;
                end
            end

            assign level[ch] = stable;
            assign pulse[ch] = rise;
        end
    endgenerate

    assign Sensor_Clean = level[0];
    assign WR_Level     = level[1];
    assign Reprog_Level = level[2];
    assign Sensor_Rise  = pulse[0];
    assign WR_Pulse     = pulse[1];
    assign Reprog_Pulse = pulse[2];

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_input_debouncer
//  Purpose  : Self-checking bench for input_debouncer (DEBOUNCE_CYCLES = 4).
//             Directed scenarios plus randomised inputs, compared against a
//             history-window reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

    localparam int D = 4;

    logic clk;
    logic Reset;
    logic Sensor;
    logic Walk_Request;
    logic Reprogram;
    logic Sensor_Clean;
    logic WR_Level;
    logic Reprog_Level;
    logic WR_Pulse;
    logic Reprog_Pulse;
    logic Sensor_Rise;

    input_debouncer #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (16)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .Sensor      (Sensor),
        .Walk_Request(Walk_Request),
        .Reprogram   (Reprogram),
        .Sensor_Clean(Sensor_Clean),
        .WR_Level    (WR_Level),
        .Reprog_Level(Reprog_Level),
        .WR_Pulse    (WR_Pulse),
        .Reprog_Pulse(Reprog_Pulse),
        .Sensor_Rise (Sensor_Rise)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // hist holds the raw input vector sampled at every edge since reset.
    // The debounced level toggles when the raw values seen two edges earlier
    // (synchroniser delay) disagree with it for the last D edges in a row.
    logic [2:0] hist[$];
    logic [2:0] m_stable;
    logic [2:0] m_rise;

    task automatic model_clear();
        hist.delete();
        m_stable = 3'b000;
        m_rise   = 3'b000;
    endtask

    task automatic model_edge(input logic [2:0] raw);
        int n;
        hist.push_back(raw);
        n = hist.size();
        for (int c = 0; c < 3; c++) begin
            bit all_diff = 1'b1;
            for (int i = 0; i < D; i++) begin
                int idx = n - 1 - i - 2;
                logic [2:0] e = 3'b000;
                if (idx >= 0) e = hist[idx];
                if (e[c] == m_stable[c]) all_diff = 1'b0;
            end
            m_rise[c] = all_diff && !m_stable[c];
            if (all_diff) m_stable[c] = ~m_stable[c];
        end
        if (hist.size() > 16) void'(hist.pop_front());
    endtask

    // ---------------- stimulus helpers ----------------
    logic [2:0] cur;
    int edge_n = 0;
    int pc[3];
    int fpe[3];

    task automatic apply();
        Sensor       = cur[0];
        Walk_Request = cur[1];
        Reprogram    = cur[2];
    endtask

    task automatic clear_stats();
        for (int c = 0; c < 3; c++) begin
            pc[c]  = 0;
            fpe[c] = -1;
        end
    endtask

    function automatic logic [5:0] outs();
        return {Reprog_Pulse, WR_Pulse, Sensor_Rise, Reprog_Level, WR_Level, Sensor_Clean};
    endfunction

    // One clock edge: update the model, then compare just after the edge.
    task automatic step();
        logic [2:0] p;
        @(posedge clk);
        if (Reset) model_clear();
        else       model_edge(cur);
        edge_n++;
        #1;
        check("level", {Reprog_Level, WR_Level, Sensor_Clean}, m_stable);
        check("pulse", {Reprog_Pulse, WR_Pulse, Sensor_Rise}, m_rise);
        p = {Reprog_Pulse, WR_Pulse, Sensor_Rise};
        for (int c = 0; c < 3; c++) begin
            if (p[c]) begin
                pc[c]++;
                if (fpe[c] < 0) fpe[c] = edge_n;
            end
        end
    endtask

    int e0;
    int fall_ok;
    logic [5:0] pat;

    initial begin
        Reset = 1'b1;
        cur   = 3'b000;
        apply();
        model_clear();
        clear_stats();
        repeat (3) step();
        check("reset_outputs", outs(), 0);
        Reset = 1'b0;
        repeat (6) step();

        // Clean walk press, held 20 cycles.
        clear_stats();
        e0 = edge_n + 1;
        cur[1] = 1'b1; apply();
        repeat (20) step();
        check("press_count", pc[1], 1);
        check("press_latency", fpe[1] - e0, 5);

        // Release: level falls after the sixth edge, no pulse.
        clear_stats();
        cur[1] = 1'b0; apply();
        repeat (5) step();
        check("release_hold", WR_Level, 1);
        step();
        check("release_fall", WR_Level, 0);
        repeat (6) step();
        check("release_nopulse", pc[1], 0);

        // Bouncy reprogram press 1,0,1,1,0,1 then hold high.
        clear_stats();
        pat = 6'b101101;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) e0 = edge_n + 1;
            cur[2] = pat[5 - i]; apply();
            step();
        end
        repeat (15) step();
        check("bounce_count", pc[2], 1);
        check("bounce_latency", fpe[2] - e0, 5);
        cur[2] = 1'b0; apply();
        repeat (10) step();

        // Sensor glitch of 3 cycles is rejected.
        clear_stats();
        cur[0] = 1'b1; apply();
        repeat (3) step();
        cur[0] = 1'b0; apply();
        repeat (10) step();
        check("glitch3_count", pc[0], 0);

        // Sensor high for 4 cycles is accepted once.
        clear_stats();
        e0 = edge_n + 1;
        cur[0] = 1'b1; apply();
        repeat (4) step();
        cur[0] = 1'b0; apply();
        repeat (12) step();
        check("glitch4_count", pc[0], 1);
        check("glitch4_latency", fpe[0] - e0, 5);

        // Asynchronous reset with all inputs high, then release.
        cur = 3'b111; apply();
        repeat (12) step();
        check("all_high_levels", outs(), 6'b000111);
        Reset = 1'b1;
        #1;
        check("async_reset", outs(), 0);
        model_clear();
        repeat (2) step();
        Reset = 1'b0;
        clear_stats();
        e0 = edge_n + 1;
        repeat (12) step();
        for (int c = 0; c < 3; c++) begin
            check("rst_release_count", pc[c], 1);
            check("rst_release_latency", fpe[c] - e0, 5);
        end

        // Reset in the middle of a walk count.
        cur = 3'b000; apply();
        repeat (12) step();
        clear_stats();
        cur[1] = 1'b1; apply();
        repeat (4) step();
        Reset = 1'b1;
        #1;
        check("midcount_reset", outs(), 0);
        model_clear();
        repeat (2) step();
        Reset = 1'b0;
        e0 = edge_n + 1;
        repeat (10) step();
        check("midcount_count", pc[1], 1);
        check("midcount_latency", fpe[1] - e0, 5);

        // All three inputs rise together.
        cur = 3'b000; apply();
        repeat (12) step();
        clear_stats();
        e0 = edge_n + 1;
        cur = 3'b111; apply();
        repeat (10) step();
        for (int c = 0; c < 3; c++) check("together_latency", fpe[c] - e0, 5);

        // Walk and reprogram rise while the sensor chatters every cycle.
        cur = 3'b000; apply();
        repeat (12) step();
        clear_stats();
        e0 = edge_n + 1;
        for (int i = 0; i < 12; i++) begin
            cur = {2'b11, i[0]}; apply();
            step();
        end
        check("indep_wr", fpe[1] - e0, 5);
        check("indep_rp", fpe[2] - e0, 5);
        check("indep_sensor_quiet", pc[0], 0);

        // Randomised inputs: each channel flips with probability about 1/6.
        cur = 3'b000; apply();
        repeat (12) step();
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 3; c++)
                if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
            apply();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/input_debouncer.md
# input_debouncer

Input-conditioning stage between the board pins and the traffic controller core. It synchronises, debounces and edge-detects the three user inputs (vehicle sensor, walk button, reprogram button). The core receives a clean sensor level plus single-cycle request pulses. The pulses drive the walk-request latch and the time-parameter write, so one bouncy button press yields exactly one walk request or one parameter write.

## Interface
- DEBOUNCE_CYCLES, default 16: consecutive `clk` cycles a synchronised input must differ from its debounced value before the debounced value changes. Legal range 1..65535.
- CNT_W, default 16: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- clk  in  1  system clock; every register is on its rising edge.
- Reset  in  1  asynchronous, active-high; clears every register immediately.
- Sensor  in  1  raw vehicle-sensor level, asynchronous to `clk`.
- Walk_Request  in  1  raw walk push-button, asynchronous to `clk`.
- Reprogram  in  1  raw reprogram push-button, asynchronous to `clk`.
- Sensor_Clean  out  1  debounced sensor level.
- WR_Level  out  1  debounced walk-button level.
- Reprog_Level  out  1  debounced reprogram-button level.
- WR_Pulse  out  1  one-cycle pulse on each debounced 0->1 of the walk button.
- Reprog_Pulse  out  1  one-cycle pulse on each debounced 0->1 of the reprogram button.
- Sensor_Rise  out  1  one-cycle pulse on each debounced 0->1 of the sensor.

## Operation
- Three identical, fully independent channels (Sensor, Walk_Request, Reprogram). There is no cross-channel interaction.
- Per-channel registers:
  - sync1, sync2: two-flop synchroniser; the raw input feeds sync1.
  - cnt[CNT_W-1:0]: debounce counter.
  - stable: the debounced level, driven out as the level output.
  - rise: the edge pulse, driven out as the pulse output.
- Every edge, per channel:
  - If sync2 == stable: cnt <= 0, rise <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0, rise <= sync2. The pulse fires only on a 0->1 change.
  - Else: cnt <= cnt+1, rise <= 0.
- A deviation shorter than DEBOUNCE_CYCLES consecutive sync2 cycles leaves stable unchanged. Any return to agreement clears cnt; the counter never accumulates across glitches.
- Falling transitions are debounced identically but produce no pulse.
- cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Reset asserted (any time, including mid-count):
  - sync1, sync2, cnt, stable and rise all go to 0 asynchronously.
  - Any pulse in progress is cut short.
- Reset released with an input already held high: treated as a fresh 0->1. The pulse fires after the normal latency. This is intentional; the core ignores pulses while its own reset is active.

## Timing
- Reset values: all six outputs 0.
- Rise latency:
  - Let e0 be the first edge at which sync1 samples the raw input high, with the input held high afterwards.
  - sync2 is high after e1.
  - The counter runs on edges e2..e(DEBOUNCE_CYCLES).
  - stable and rise go high after edge e(DEBOUNCE_CYCLES+1).
  - rise returns low after the next edge.
  - Total: DEBOUNCE_CYCLES+2 edges from capture to output.
- Fall latency: same edge count; no pulse.
- Pulse width is exactly one `clk` cycle. Minimum spacing between two pulses on one channel is 2*DEBOUNCE_CYCLES cycles: one rise settle plus one fall settle.
- DEBOUNCE_CYCLES=1: stable follows sync2 with one extra register stage. The latency formula still holds (3 edges).
- Simultaneous edges on several channels: each channel behaves independently. Pulses may coincide in the same cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: assert Reset mid-simulation with all inputs high -> every output reads 0 in the same cycle. After release with inputs held high, WR_Pulse, Reprog_Pulse and Sensor_Rise each fire exactly once, 6 edges after the first capture edge.
- Clean press: Walk_Request 0->1 and held 20 cycles -> WR_Level rises after edge e5 and WR_Pulse is high for exactly 1 cycle. Release -> WR_Level falls 6 edges later with no pulse.
- Bounce: Reprogram toggles 1,0,1,1,0,1 (one cycle each), then holds 1 -> no pulse during the bounce. One Reprog_Pulse occurs 6 edges after the final sustained high is captured.
- Glitch rejection: Sensor high for exactly 3 synchronised cycles, then 0 -> Sensor_Clean stays 0 and Sensor_Rise never asserts. The same input with 4 cycles high -> Sensor_Clean pulses high and Sensor_Rise fires once.
- Reset mid-count: Walk_Request high, Reset asserted after 2 counting edges, then released with the input still high -> no pulse before reset, counter restarts from 0, one WR_Pulse 6 edges after release capture.
- Independence: all three inputs rise on the same edge -> all three pulses assert in the same cycle. Sensor glitching at the same time must not disturb the WR or Reprogram timing.
